// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register. Latency: ROM word at imem_addr lands in IF/ID one cycle later.
// Backpressure: stall_mem or hazard hold the PC and IF/ID; a flush or an interrupt entry inserts one NOP bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        stall_mem,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        rti_ret,
  input  logic        irq,
  input  logic        interrupt_branch_alert,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        irq_ack,
  output logic        in_isr
);

  typedef enum logic {RUN, IN_ISR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cpc_q, cpc_d;
  logic [31:0] npc_q, npc_d;
  logic        pend_q, pend_d;
  logic        ack_q, ack_d;
  logic        take_irq;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // A JAL sitting in decode would lose its link/redirect if the interrupt cut in here.
  assign take_irq = (state_q == RUN) && pend_q && !hazard && !interrupt_branch_alert &&
                    (instr_q[6:0] != 7'b1101111);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    npc_d   = npc_q;
    pend_d  = pend_q | irq;
    ack_d   = 1'b0;

    if (stall_mem) begin
      // everything except the pending-interrupt latch is frozen
    end else if (flush) begin
      instr_d = NOP_INSTR;
      cpc_d   = 32'd0;
      npc_d   = 32'd0;
      if (rti_ret) begin
        pc_d    = epc_q;
        state_d = RUN;
      end else begin
        pc_d = branch_target & ~32'h3;
      end
    end else if (take_irq) begin
      // The word currently at pc is dropped; epc points back at it so it is re-fetched.
      epc_d   = pc_q;
      pc_d    = IRQ_VECTOR;
      instr_d = NOP_INSTR;
      cpc_d   = 32'd0;
      npc_d   = 32'd0;
      pend_d  = 1'b0;
      ack_d   = 1'b1;
      state_d = IN_ISR;
    end else if (hazard) begin
      // hold pc and IF/ID
    end else begin
      instr_d = imem_rdata;
      cpc_d   = pc_q;
      npc_d   = pc_plus4;
      pc_d    = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      cpc_q   <= 32'd0;
      npc_q   <= 32'd0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
      npc_q   <= npc_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign curr_pc     = cpc_q;
  assign next_pc     = npc_q;
  assign irq_ack     = ack_q;
  assign in_isr      = (state_q == IN_ISR);

endmodule
